priority_arbiter_8: RTL and testbench

Sequential 8-requester arbiter that shares a single downstream resource, such as a bus or an encoder datapath, among eight requesters. It sits in front of the 8-to-3 priority encoding path. Each cycle it resolves the request vector to one owner, either by fixed priority (highest index wins, same ordering as the priority encoder) or by round robin. It holds that grant until the owner releases it or a hold-time limit expires, and it reports the owner both one-hot and as a 3-bit index.

---
 rtl/priority_arbiter_8.sv | 106 ++++++++++
 tb/tb_priority_arbiter_8.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter_8.sv
// rtl/priority_arbiter_8.sv - 8-requester fixed-priority / round-robin arbiter with hold limit

module priority_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       mode,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [2:0]    ptr;
  // one-hot mask of the requester that just timed out; zero means nothing skipped
  logic [7:0]    skip;

  logic [7:0] eligible;
  logic [2:0] fixed_w;
  logic [2:0] rr_w;
  logic       rr_found;
  logic [2:0] rr_idx;
  logic [2:0] win;

  // winner selection: highest index for fixed, search downward from ptr-1 for round robin
  always_comb begin
    eligible = req & ~skip;
    fixed_w  = 3'd0;
    rr_w     = 3'd0;
    rr_found = 1'b0;
    rr_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) fixed_w = 3'(i);
    end
    for (int i = 1; i <= 8; i++) begin
      rr_idx = ptr - 3'(i);
      if (!rr_found && eligible[rr_idx]) begin
        rr_w     = rr_idx;
        rr_found = 1'b1;
      end
    end
    win = mode ? rr_w : fixed_w;
  end

  // arbitration state machine with registered grant outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 8'd0;
      grant_id    <= 3'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      ptr         <= 3'd0;
      skip        <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          skip    <= 8'd0;
          if (|eligible) begin
            state       <= GRANT;
            grant       <= 8'b1 << win;
            grant_id    <= win;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            ptr         <= win;
          end
        end
        GRANT: begin
          if (!req[grant_id]) begin
            // release wins over a coincident hold-limit expiry
            state       <= IDLE;
            grant       <= 8'd0;
            grant_id    <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state       <= IDLE;
            grant       <= 8'd0;
            grant_id    <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
            skip        <= grant;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_arbiter_8.sv
// tb/tb_priority_arbiter_8.sv - directed self-checking bench for priority_arbiter_8

module tb_priority_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       mode;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int n_checks = 0;
  int n_pass   = 0;

  priority_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .mode        (mode),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_owner(input string tag, input int id);
    check({tag, " valid"}, 32'(grant_valid), 32'd1);
    check({tag, " id"}, 32'(grant_id), 32'(id));
    check({tag, " grant"}, 32'(grant), 32'(8'b1 << id));
    check({tag, " timeout"}, 32'(timeout), 32'd0);
  endtask

  task automatic expect_idle(input string tag, input logic to);
    check({tag, " valid"}, 32'(grant_valid), 32'd0);
    check({tag, " grant"}, 32'(grant), 32'd0);
    check({tag, " id"}, 32'(grant_id), 32'd0);
    check({tag, " timeout"}, 32'(timeout), 32'(to));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'd0;
    mode  = 1'b0;
    step();
    step();
    expect_idle("reset", 1'b0);

    // basic fixed grant, then async reset mid-grant
    rst_n = 1'b1;
    req   = 8'b0010_0100;
    step();
    expect_owner("basic", 5);
    step();
    expect_owner("basic hold", 5);
    #2 rst_n = 1'b0;
    #1 expect_idle("async reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'd0;
    step();
    expect_idle("post reset", 1'b0);

    // fixed priority, no preemption
    req = 8'b0000_0100;
    step();
    expect_owner("fp own2", 2);
    req = 8'b1000_0100;
    step();
    expect_owner("fp nopreempt", 2);
    req = 8'b1000_0000;
    step();
    expect_idle("fp turnaround", 1'b0);
    step();
    expect_owner("fp own7", 7);
    req = 8'd0;
    step();
    expect_idle("fp release", 1'b0);

    // round robin fairness from reset pointer
    do_reset();
    mode = 1'b1;
    req  = 8'hFF;
    step();
    expect_owner("rr first", 7);
    for (int k = 0; k < 8; k++) begin
      int cur;
      int nxt;
      cur = 7 - k;
      nxt = (cur + 7) % 8;
      req = 8'hFF & ~(8'b1 << cur);
      step();
      expect_idle($sformatf("rr gap%0d", k), 1'b0);
      req = 8'hFF;
      step();
      expect_owner($sformatf("rr seq%0d", k), nxt);
    end
    req = 8'd0;
    step();

    // timeout with a competing requester: skip hands over to 0
    do_reset();
    mode = 1'b0;
    req  = 8'b0000_1001;
    for (int c = 0; c < 4; c++) begin
      step();
      expect_owner($sformatf("to cyc%0d", c), 3);
    end
    step();
    expect_idle("to pulse", 1'b1);
    step();
    expect_owner("to skip", 0);
    req = 8'd0;
    step();
    expect_idle("to release", 1'b0);

    // timeout with sole requester: extra idle cycle then re-grant
    req = 8'b0000_0001;
    for (int c = 0; c < 4; c++) begin
      step();
      expect_owner($sformatf("sole cyc%0d", c), 0);
    end
    step();
    expect_idle("sole pulse", 1'b1);
    step();
    expect_idle("sole skipidle", 1'b0);
    step();
    expect_owner("sole regrant", 0);
    req = 8'd0;
    step();
    expect_idle("sole release", 1'b0);

    // release on the final hold cycle: no pulse, no skip
    req = 8'b0000_1000;
    for (int c = 0; c < 4; c++) begin
      step();
      expect_owner($sformatf("last cyc%0d", c), 3);
    end
    req = 8'd0;
    step();
    expect_idle("last nopulse", 1'b0);
    req = 8'b0000_1000;
    step();
    expect_owner("last noskip", 3);
    req = 8'd0;
    step();
    expect_idle("end", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
